// File: rtl/ctrl_retire_queue.sv
// ctrl_retire_queue
// Retire-side control queue for the branch predictor.
//
// Each cycle the retire stage presents a group of up to RETIRE_WIDTH retiring
// conditional branches (slot 0 is the oldest). An accepted group is:
//   * forwarded, registered, to the BHR retire-history inputs one cycle later
//   * buffered in program order in a FIFO, which the training side drains one
//     outcome per cycle so training can stall without blocking retirement.
//
// Ports:
//   clk            - clock, all state changes on posedge
//   reset          - asynchronous, active-low reset
//   retire_valid_i - per-slot mask, slot retires a conditional branch
//   retire_dir_i   - per-slot direction (1 = taken), ignored where not valid
//   upd_stall_i    - training side busy, blocks pops
//   ready_o        - queue can take a full retire group this cycle
//   update_ret_o   - registered accepted valid mask (BHR update_ret)
//   dir_ret_o      - registered accepted directions, masked by valid
//   update_upd_o   - one training outcome presented this cycle
//   dir_upd_o      - direction of that outcome
//   count_o        - current occupancy
//   overflow_o     - sticky, a group was presented while ready_o was low

module ctrl_retire_queue #(
   parameter int RETIRE_WIDTH = 4,
   parameter int DEPTH        = 16,
   parameter int DEPTH_LOG    = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [RETIRE_WIDTH-1:0] retire_valid_i,
   input  logic [RETIRE_WIDTH-1:0] retire_dir_i,
   input  logic                    upd_stall_i,
   output logic                    ready_o,
   output logic [RETIRE_WIDTH-1:0] update_ret_o,
   output logic [RETIRE_WIDTH-1:0] dir_ret_o,
   output logic                    update_upd_o,
   output logic                    dir_upd_o,
   output logic [DEPTH_LOG:0]      count_o,
   output logic                    overflow_o
);

   localparam int CW = DEPTH_LOG + 1;

   logic                 mem [DEPTH];
   logic [DEPTH_LOG-1:0] head;
   logic [DEPTH_LOG-1:0] tail;
   logic [CW-1:0]        count;

   logic                 accept;
   logic                 pop;
   logic [CW-1:0]        push_cnt;
   logic [DEPTH_LOG-1:0] slot_off [RETIRE_WIDTH];

   // Readiness is judged on the pre-edge occupancy only; a pop happening in
   // the same cycle earns no credit, which keeps ready_o off the pop path.
   assign ready_o = (count <= CW'(DEPTH - RETIRE_WIDTH));
   assign accept  = (|retire_valid_i) && ready_o;
   assign pop     = (count != '0) && !upd_stall_i;
   assign count_o = count;

   // Compaction of the retire group: each valid slot lands at tail plus the
   // number of valid slots older than it, so FIFO order equals slot order.
   // The running total at the end is the number of entries pushed.
   always_comb begin
      logic [CW-1:0] run;
      run = '0;
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
         slot_off[i] = run[DEPTH_LOG-1:0];
         if (retire_valid_i[i]) begin
            run = run + CW'(1);
         end
      end
      push_cnt = run;
   end

   // Storage array carries no reset; entries are only meaningful between
   // head and tail, and those pointers are what reset clears.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (retire_valid_i[i]) begin
               mem[tail + slot_off[i]] <= retire_dir_i[i];
            end
         end
      end
   end

   // Pointers, occupancy, registered retire/training outputs and the sticky
   // overflow flag. Pointer wrap is plain modulo-DEPTH overflow. A pop only
   // reads entries present before this edge, so nothing bypasses the FIFO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         update_ret_o <= '0;
         dir_ret_o    <= '0;
         update_upd_o <= 1'b0;
         dir_upd_o    <= 1'b0;
         overflow_o   <= 1'b0;
      end else begin
         if (accept) begin
            update_ret_o <= retire_valid_i;
            dir_ret_o    <= retire_dir_i & retire_valid_i;
            tail         <= tail + push_cnt[DEPTH_LOG-1:0];
         end else begin
            update_ret_o <= '0;
            dir_ret_o    <= '0;
         end

         if ((|retire_valid_i) && !ready_o) begin
            overflow_o <= 1'b1;
         end

         if (pop) begin
            update_upd_o <= 1'b1;
            dir_upd_o    <= mem[head];
            head         <= head + DEPTH_LOG'(1);
         end else begin
            update_upd_o <= 1'b0;
            dir_upd_o    <= 1'b0;
         end

         count <= count + (accept ? push_cnt : CW'(0)) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_ctrl_retire_queue.sv
// tb_ctrl_retire_queue
// Directed bench for ctrl_retire_queue. Every step drives one retire group,
// clocks once and compares all outputs against a small behavioural queue
// model; key points additionally get hand-computed literal checks.

module tb_ctrl_retire_queue;

   logic       clk;
   logic       reset;
   logic [3:0] retire_valid_i;
   logic [3:0] retire_dir_i;
   logic       upd_stall_i;
   logic       ready_o;
   logic [3:0] update_ret_o;
   logic [3:0] dir_ret_o;
   logic       update_upd_o;
   logic       dir_upd_o;
   logic [4:0] count_o;
   logic       overflow_o;

   int vectors = 0;
   int errors  = 0;

   bit model_q [$];
   bit model_ovf;

   ctrl_retire_queue #(.RETIRE_WIDTH(4), .DEPTH(16), .DEPTH_LOG(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .retire_valid_i (retire_valid_i),
      .retire_dir_i   (retire_dir_i),
      .upd_stall_i    (upd_stall_i),
      .ready_o        (ready_o),
      .update_ret_o   (update_ret_o),
      .dir_ret_o      (dir_ret_o),
      .update_upd_o   (update_upd_o),
      .dir_upd_o      (dir_upd_o),
      .count_o        (count_o),
      .overflow_o     (overflow_o)
   );

   // Free-running clock, posedges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clocked step: predict from the model, drive, clock, compare.
   task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] dir,
                                input logic stall);
      bit         rdy;
      bit         acc;
      bit         pp;
      bit         exp_dupd;
      logic [3:0] exp_ret;
      logic [3:0] exp_dret;
      rdy      = (model_q.size() <= 12);
      acc      = (valid != 4'b0) && rdy;
      pp       = (model_q.size() != 0) && !stall;
      exp_dupd = pp ? model_q[0] : 1'b0;
      exp_ret  = acc ? valid : 4'b0;
      exp_dret = acc ? (valid & dir) : 4'b0;
      if (pp) void'(model_q.pop_front());
      if (acc) begin
         for (int i = 0; i < 4; i++) begin
            if (valid[i]) model_q.push_back(dir[i]);
         end
      end else if (valid != 4'b0) begin
         model_ovf = 1'b1;
      end

      retire_valid_i = valid;
      retire_dir_i   = dir;
      upd_stall_i    = stall;
      @(posedge clk);
      #1;
      checkOutput("update_ret", update_ret_o, exp_ret);
      checkOutput("dir_ret", dir_ret_o, exp_dret);
      checkOutput("update_upd", update_upd_o, pp);
      checkOutput("dir_upd", dir_upd_o, exp_dupd);
      checkOutput("count", count_o, model_q.size());
      checkOutput("ready", ready_o, model_q.size() <= 12);
      checkOutput("overflow", overflow_o, model_ovf);
   endtask

   logic [11:0] mix [24] = '{
      12'h320, 12'h001, 12'h751, 12'h880, 12'hFA1, 12'h100,
      12'h000, 12'hC41, 12'h550, 12'h000, 12'h221, 12'hE60,
      12'h910, 12'h001, 12'hFF0, 12'h400, 12'h621, 12'h000,
      12'hB30, 12'h111, 12'h000, 12'hD90, 12'hA80, 12'h000
   };

   initial begin
      reset          = 1'b0;
      retire_valid_i = 4'b0;
      retire_dir_i   = 4'b0;
      upd_stall_i    = 1'b0;
      model_ovf      = 1'b0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      checkOutput("rst_count", count_o, 0);
      checkOutput("rst_ready", ready_o, 1);
      checkOutput("rst_update_ret", update_ret_o, 0);
      checkOutput("rst_update_upd", update_upd_o, 0);
      checkOutput("rst_overflow", overflow_o, 0);

      // Single branch, then its training pop one cycle later.
      applyStimulus(4'b0001, 4'b0001, 1'b0);
      checkOutput("tp1_ret", update_ret_o, 4'b0001);
      checkOutput("tp1_count", count_o, 1);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("tp1_upd", {update_upd_o, dir_upd_o}, 2'b11);
      checkOutput("tp1_count0", count_o, 0);

      // Sparse group under stall, then drained in slot order 1,0,1.
      applyStimulus(4'b1011, 4'b1001, 1'b1);
      checkOutput("tp2_dret", dir_ret_o, 4'b1001);
      checkOutput("tp2_count", count_o, 3);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("tp2_d0", dir_upd_o, 1);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("tp2_d1", dir_upd_o, 0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("tp2_d2", dir_upd_o, 1);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("tp2_idle", update_upd_o, 0);

      // Fill to full, then an overflowing group is dropped.
      applyStimulus(4'b1111, 4'b1010, 1'b1);
      applyStimulus(4'b1111, 4'b0110, 1'b1);
      applyStimulus(4'b1111, 4'b1100, 1'b1);
      checkOutput("tp3_count12", count_o, 12);
      checkOutput("tp3_ready12", ready_o, 1);
      applyStimulus(4'b1111, 4'b0011, 1'b1);
      checkOutput("tp3_count16", count_o, 16);
      checkOutput("tp3_ready16", ready_o, 0);
      applyStimulus(4'b1111, 4'b1111, 1'b1);
      checkOutput("tp3_drop_ret", update_ret_o, 0);
      checkOutput("tp3_ovf", overflow_o, 1);
      checkOutput("tp3_hold16", count_o, 16);
      for (int i = 0; i < 16; i++) applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("tp3_drained", count_o, 0);

      // Push and pop in the same cycle from count 5.
      applyStimulus(4'b1111, 4'b0101, 1'b1);
      applyStimulus(4'b0001, 4'b0001, 1'b1);
      checkOutput("tp4_count5", count_o, 5);
      applyStimulus(4'b1111, 4'b1001, 1'b0);
      checkOutput("tp4_count8", count_o, 8);
      checkOutput("tp4_pop", {update_upd_o, dir_upd_o}, 2'b11);

      // Mixed traffic, pointers wrap repeatedly.
      for (int i = 0; i < 24; i++) applyStimulus(mix[i][11:8], mix[i][7:4], mix[i][0]);
      for (int i = 0; i < 40 && model_q.size() != 0; i++)
         applyStimulus(4'b0000, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("tp4_empty", count_o, 0);

      // Empty queue does not pop a same-cycle push.
      applyStimulus(4'b0100, 4'b0100, 1'b0);
      checkOutput("tp5_nopop", update_upd_o, 0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("tp5_pop", {update_upd_o, dir_upd_o}, 2'b11);

      // Asynchronous reset mid-operation with 7 entries buffered.
      applyStimulus(4'b1111, 4'b1111, 1'b1);
      applyStimulus(4'b0111, 4'b0101, 1'b1);
      checkOutput("tp6_count7", count_o, 7);
      #2 reset = 1'b0;
      #1;
      model_q.delete();
      model_ovf = 1'b0;
      checkOutput("tp6_async_count", count_o, 0);
      checkOutput("tp6_async_ret", update_ret_o, 0);
      checkOutput("tp6_async_dret", dir_ret_o, 0);
      checkOutput("tp6_async_ovf", overflow_o, 0);
      checkOutput("tp6_async_ready", ready_o, 1);
      #2 reset = 1'b1;
      applyStimulus(4'b0001, 4'b0001, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("tp6_repop", {update_upd_o, dir_upd_o}, 2'b11);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
